// File: rtl/cobra_pkg.sv
// rtl/cobra_pkg.sv - shared types, field positions and ALU opcodes for cobra_mc_core
package cobra_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        EXEC    = 2'd1,
        WAIT_SW = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        WS_CONST = 2'd0,
        WS_ALU   = 2'd1,
        WS_SW    = 2'd2,
        WS_ZERO  = 2'd3
    } ws_t;

    localparam int J_BIT     = 31;
    localparam int B_BIT     = 30;
    localparam int WS_HI     = 29;
    localparam int WS_LO     = 28;
    localparam int ALUOP_HI  = 27;
    localparam int ALUOP_LO  = 23;
    localparam int RA1_HI    = 22;
    localparam int RA1_LO    = 18;
    localparam int RA2_HI    = 17;
    localparam int RA2_LO    = 13;
    localparam int OFFS_HI   = 12;
    localparam int OFFS_LO   = 5;
    localparam int CONST_HI  = 27;
    localparam int CONST_LO  = 5;
    localparam int WA_HI     = 4;
    localparam int WA_LO     = 0;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SLL  = 5'b00001;
    localparam logic [4:0] ALU_SLTS = 5'b00010;
    localparam logic [4:0] ALU_SLTU = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_AND  = 5'b00111;
    localparam logic [4:0] ALU_SUB  = 5'b01000;
    localparam logic [4:0] ALU_SRA  = 5'b01101;
    localparam logic [4:0] ALU_EQ   = 5'b11000;
    localparam logic [4:0] ALU_NE   = 5'b11001;
    localparam logic [4:0] ALU_LTS  = 5'b11100;
    localparam logic [4:0] ALU_GES  = 5'b11101;
    localparam logic [4:0] ALU_LTU  = 5'b11110;
    localparam logic [4:0] ALU_GEU  = 5'b11111;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - CYBERcobra ALU: arithmetic/logic results plus comparison flag
module alu
    import cobra_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      alu_op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o,
    output logic            flag_o
);
    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] w_shamt;
    assign w_shamt = b_i[SH_W-1:0];

    always_comb begin
        result_o = '0;
        flag_o   = 1'b0;
        case (alu_op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            ALU_SLL:  result_o = a_i << w_shamt;
            ALU_SRL:  result_o = a_i >> w_shamt;
            ALU_SRA:  result_o = $unsigned($signed(a_i) >>> w_shamt);
            ALU_SLTS: result_o = XLEN'($signed(a_i) < $signed(b_i));
            ALU_SLTU: result_o = XLEN'(a_i < b_i);
            ALU_EQ:   flag_o   = (a_i == b_i);
            ALU_NE:   flag_o   = (a_i != b_i);
            ALU_LTS:  flag_o   = ($signed(a_i) < $signed(b_i));
            ALU_GES:  flag_o   = ($signed(a_i) >= $signed(b_i));
            ALU_LTU:  flag_o   = (a_i < b_i);
            ALU_GEU:  flag_o   = (a_i >= b_i);
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/cobra_rf.sv
// rtl/cobra_rf.sv - 32 x XLEN register file, two async reads, one sync write, x0 tied to zero
module cobra_rf #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [4:0]      wa_i,
    input  logic [XLEN-1:0] wd_i,
    input  logic [4:0]      ra1_i,
    input  logic [4:0]      ra2_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o
);
    logic [XLEN-1:0] r_mem [32];

    always_ff @(posedge clk_i) begin
        if (we_i && (wa_i != 5'd0)) begin
            r_mem[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == 5'd0) ? '0 : r_mem[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? '0 : r_mem[ra2_i];

endmodule

// File: rtl/cobra_mc_core.sv
// rtl/cobra_mc_core.sv - multi-cycle CYBERcobra core with req/ack fetch and switch handshake
module cobra_mc_core
    import cobra_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              SW_W     = 16,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic [SW_W-1:0] sw_i,
    input  logic            sw_valid_i,
    output logic            sw_ready_o,
    output logic [XLEN-1:0] out_o,
    output logic            out_valid_o
);
    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_out;
    logic            r_out_valid;

    logic            w_j;
    logic            w_b;
    ws_t             w_ws;
    logic [XLEN-1:0] w_const;
    logic [PC_W-1:0] w_offs;
    logic [XLEN-1:0] w_sw_ext;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;
    logic [XLEN-1:0] w_alu_res;
    logic            w_flag;
    logic            w_needs_sw;
    logic            w_commit;
    logic            w_we;
    logic [XLEN-1:0] w_wd;
    logic [PC_W-1:0] w_pc_next;

    assign w_j      = r_ir[J_BIT];
    assign w_b      = r_ir[B_BIT];
    assign w_ws     = ws_t'(r_ir[WS_HI:WS_LO]);
    assign w_const  = {{(XLEN-23){r_ir[CONST_HI]}}, r_ir[CONST_HI:CONST_LO]};
    assign w_offs   = {{(PC_W-10){r_ir[OFFS_HI]}}, r_ir[OFFS_HI:OFFS_LO], 2'b00};
    assign w_sw_ext = {{(XLEN-SW_W){sw_i[SW_W-1]}}, sw_i};

    cobra_rf #(.XLEN(XLEN)) u_rf (
        .clk_i (clk_i),
        .we_i  (w_we),
        .wa_i  (r_ir[WA_HI:WA_LO]),
        .wd_i  (w_wd),
        .ra1_i (r_ir[RA1_HI:RA1_LO]),
        .ra2_i (r_ir[RA2_HI:RA2_LO]),
        .rd1_o (w_rd1),
        .rd2_o (w_rd2)
    );

    alu #(.XLEN(XLEN)) u_alu (
        .alu_op_i (r_ir[ALUOP_HI:ALUOP_LO]),
        .a_i      (w_rd1),
        .b_i      (w_rd2),
        .result_o (w_alu_res),
        .flag_o   (w_flag)
    );

    // Only a plain (non-jump, non-branch) switch writeback parks in WAIT_SW
    assign w_needs_sw = ~w_j & ~w_b & (w_ws == WS_SW);
    assign w_commit   = ((r_state == EXEC) & ~w_needs_sw) |
                        ((r_state == WAIT_SW) & sw_valid_i);
    assign w_we       = w_commit & ~(w_j | w_b);

    always_comb begin
        w_wd = '0;
        case (w_ws)
            WS_CONST: w_wd = w_const;
            WS_ALU:   w_wd = w_alu_res;
            WS_SW:    w_wd = w_sw_ext;
            default:  w_wd = '0;
        endcase
    end

    assign w_pc_next = (w_j | (w_b & w_flag)) ? (r_pc + w_offs) : (r_pc + PC_W'(4));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= FETCH;
            r_pc        <= RESET_PC;
            r_ir        <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_commit;
            if (w_commit) begin
                r_out <= w_rd1;
                r_pc  <= w_pc_next;
            end
            case (r_state)
                FETCH: begin
                    if (imem_ack_i) begin
                        r_ir    <= imem_rdata_i;
                        r_state <= EXEC;
                    end
                end
                EXEC:    r_state <= w_needs_sw ? WAIT_SW : FETCH;
                WAIT_SW: if (sw_valid_i) r_state <= FETCH;
                default: r_state <= FETCH;
            endcase
        end
    end

    // Request is masked during reset so memory never sees a fetch while rst_i is high
    assign imem_req_o  = (r_state == FETCH) & ~rst_i;
    assign imem_addr_o = r_pc;
    assign sw_ready_o  = (r_state == WAIT_SW);
    assign out_o       = r_out;
    assign out_valid_o = r_out_valid;

endmodule
